// File: rtl/siso_qpp_interleaver.sv
// siso_qpp_interleaver: buffers one block of SISO extrinsic values and replays
// them as apriori in LTE QPP interleaved (or de-interleaved) order, issuing
// one output word every other cycle to match the SISO apriori cadence.
module siso_qpp_interleaver #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       blklen,
  input  logic              valid_blklen,
  input  logic              deint,
  input  logic [DATA_W-1:0] extrinsic,
  input  logic              valid_extrinsic,
  output logic [DATA_W-1:0] apriori,
  output logic              valid_apriori,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 6144;

  // Supported block sizes with their QPP constants: g0 = (f1+f2) mod K and
  // step = 2*f2 mod K, so the permutation is generated without multipliers.
  localparam logic [ADDR_W:0]   K_SMALL      = (ADDR_W+1)'(512);
  localparam logic [ADDR_W-1:0] G0_SMALL     = ADDR_W'(31 + 64);
  localparam logic [ADDR_W-1:0] STEP_SMALL   = ADDR_W'(2 * 64);
  localparam logic [ADDR_W:0]   K_LARGE      = (ADDR_W+1)'(6144);
  localparam logic [ADDR_W-1:0] G0_LARGE     = ADDR_W'(263 + 480);
  localparam logic [ADDR_W-1:0] STEP_LARGE   = ADDR_W'(2 * 480);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            state;
  logic [ADDR_W:0]   k_len;
  logic [ADDR_W-1:0] k_last;
  logic [ADDR_W-1:0] g_init;
  logic [ADDR_W-1:0] g_step;
  logic [ADDR_W-1:0] pi;
  logic [ADDR_W-1:0] g;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic              deint_q;
  logic              phase;
  logic              rd_done;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              blk_ok;
  logic [ADDR_W:0]   new_k;
  logic [ADDR_W-1:0] new_g0;
  logic [ADDR_W-1:0] new_step;
  logic [ADDR_W:0]   pi_sum;
  logic [ADDR_W:0]   g_sum;
  logic [ADDR_W-1:0] pi_next;
  logic [ADDR_W-1:0] g_next;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Block-size decode, QPP recurrence step and buffer port control.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    blk_ok   = (blklen == 16'd512) || (blklen == 16'd6144);
    new_k    = K_SMALL;
    new_g0   = G0_SMALL;
    new_step = STEP_SMALL;
    if (blklen == 16'd6144) begin
      new_k    = K_LARGE;
      new_g0   = G0_LARGE;
      new_step = STEP_LARGE;
    end

    // Operands are both < K, so one conditional subtract reduces mod K.
    pi_sum  = {1'b0, pi} + {1'b0, g};
    pi_next = (pi_sum >= k_len) ? ADDR_W'(pi_sum - k_len) : pi_sum[ADDR_W-1:0];
    g_sum   = {1'b0, g} + {1'b0, g_step};
    g_next  = (g_sum >= k_len) ? ADDR_W'(g_sum - k_len) : g_sum[ADDR_W-1:0];

    we      = (state == WRITE) && valid_extrinsic;
    re      = (state == READ) && !phase && !rd_done;
    wr_addr = deint_q ? pi  : cnt;
    rd_addr = deint_q ? cnt : pi;
  end

  // Block buffer: one write port from the SISO side, one synchronous read port.
  // NOTE: the storage array and its read register carry no reset; stale data is never observed.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= extrinsic;
    if (re) rd_data <= mem[rd_addr];
  end

  // Control FSM, address generation and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      k_len         <= K_SMALL;
      k_last        <= '0;
      g_init        <= '0;
      g_step        <= '0;
      pi            <= '0;
      g             <= '0;
      cnt           <= '0;
      out_cnt       <= '0;
      deint_q       <= 1'b0;
      phase         <= 1'b0;
      rd_done       <= 1'b0;
      rd_vld        <= 1'b0;
      apriori       <= '0;
      valid_apriori <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      err           <= 1'b0;
      rd_vld        <= re;
      valid_apriori <= rd_vld;
      if (rd_vld) apriori <= rd_data;

      case (state)
        IDLE: begin
          if (valid_blklen) begin
            if (blk_ok) begin
              state   <= WRITE;
              busy    <= 1'b1;
              deint_q <= deint;
              k_len   <= new_k;
              k_last  <= ADDR_W'(new_k - 1'b1);
              g_init  <= new_g0;
              g_step  <= new_step;
              pi      <= '0;
              g       <= new_g0;
              cnt     <= '0;
              out_cnt <= '0;
              phase   <= 1'b0;
              rd_done <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (valid_extrinsic) begin
            pi <= pi_next;
            g  <= g_next;
            if (cnt == k_last) begin
              // Rewind the permutation generator for the read pass.
              state <= READ;
              cnt   <= '0;
              pi    <= '0;
              g     <= g_init;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        READ: begin
          if (valid_extrinsic) err <= 1'b1;
          if (!rd_done) phase <= ~phase;
          if (re) begin
            pi <= pi_next;
            g  <= g_next;
            if (cnt == k_last) rd_done <= 1'b1;
            else               cnt     <= cnt + 1'b1;
          end
          if (valid_apriori) begin
            if (out_cnt == k_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_qpp_interleaver.sv
// Self-checking bench for siso_qpp_interleaver: directed block sequence with
// random data/gaps, checked against a closed-form QPP reference model.
module tb_siso_qpp_interleaver;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       blklen;
  logic              valid_blklen;
  logic              deint;
  logic [DATA_W-1:0] extrinsic;
  logic              valid_extrinsic;
  logic [DATA_W-1:0] apriori;
  logic              valid_apriori;
  logic              busy;
  logic              err;

  siso_qpp_interleaver #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .blklen         (blklen),
    .valid_blklen   (valid_blklen),
    .deint          (deint),
    .extrinsic      (extrinsic),
    .valid_extrinsic(valid_extrinsic),
    .apriori        (apriori),
    .valid_apriori  (valid_apriori),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_edge = 0;

  int outq[$];
  int first_valid_cyc = 0;
  int last_valid_cyc = 0;
  int busy_fall_cyc = 0;
  int err_pulses = 0;
  logic busy_prev = 1'b0;

  int data [6144];
  int expv [6144];
  int t1_out [512];

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (valid_apriori === 1'b1) begin
      if (outq.size() == 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      outq.push_back(int'(apriori));
    end
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    busy_prev = busy;
    if (err === 1'b1) err_pulses++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference permutation straight from the QPP definition.
  function automatic int qpp(input int k, input int i);
    longint f1 = (k == 512) ? 31 : 263;
    longint f2 = (k == 512) ? 64 : 480;
    longint li = i;
    return int'((f1 * li + f2 * li * li) % longint'(k));
  endfunction

  function automatic int out_at(input int i);
    if (i < outq.size()) return outq[i];
    return -1;
  endfunction

  task automatic start_block(input int k, input logic d);
    @(negedge clk);
    blklen       = 16'(k);
    deint        = d;
    valid_blklen = 1'b1;
    @(negedge clk);
    valid_blklen = 1'b0;
  endtask

  task automatic send_block(input int k, input bit gaps, input bit inject);
    for (int i = 0; i < k; i++) begin
      valid_blklen = 1'b0;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          valid_extrinsic = 1'b0;
          @(negedge clk);
        end
      end
      if (inject && i == k / 2) begin
        blklen       = 16'd512;
        valid_blklen = 1'b1;
      end
      extrinsic       = DATA_W'(data[i]);
      valid_extrinsic = 1'b1;
      if (i == k - 1) last_wr_edge = cyc + 1;
      @(negedge clk);
    end
    valid_extrinsic = 1'b0;
    valid_blklen    = 1'b0;
  endtask

  task automatic wait_done(input int k, input string tag);
    int t = 0;
    while ((outq.size() < k || busy !== 1'b0) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " completes"}, int'(t < 30000), 1);
    @(negedge clk);
  endtask

  task automatic expect_interleave(input int k);
    for (int j = 0; j < k; j++) expv[j] = data[qpp(k, j)];
  endtask

  task automatic expect_deinterleave(input int k);
    for (int i = 0; i < k; i++) expv[qpp(k, i)] = data[i];
  endtask

  task automatic check_block(input int k, input string tag);
    int bad = 0;
    check({tag, " count"}, outq.size(), k);
    for (int i = 0; i < k && i < outq.size(); i++)
      if (outq[i] !== expv[i]) bad++;
    check({tag, " mismatches"}, bad, 0);
    check({tag, " first latency"}, first_valid_cyc, last_wr_edge + 2);
    check({tag, " span"}, last_valid_cyc - first_valid_cyc + 1, 2 * k - 1);
    check({tag, " busy fall"}, busy_fall_cyc, last_valid_cyc + 1);
  endtask

  task automatic random_data(input int k);
    for (int i = 0; i < k; i++) data[i] = int'($urandom_range(0, 65535));
  endtask

  initial begin
    blklen          = '0;
    valid_blklen    = 1'b0;
    deint           = 1'b0;
    extrinsic       = '0;
    valid_extrinsic = 1'b0;
    rst             = 1'b0;
    repeat (3) @(negedge clk);
    check("reset apriori", int'(apriori), 0);
    check("reset valid_apriori", int'(valid_apriori), 0);
    check("reset busy", int'(busy), 0);
    check("reset err", int'(err), 0);
    rst = 1'b1;
    @(negedge clk);

    // K=512 interleave, ramp data, back-to-back.
    for (int i = 0; i < 512; i++) data[i] = i;
    outq.delete();
    start_block(512, 1'b0);
    check("t1 busy after strobe", int'(busy), 1);
    send_block(512, 1'b0, 1'b0);
    wait_done(512, "t1");
    check("t1 out0", out_at(0), 0);
    check("t1 out1", out_at(1), 95);
    check("t1 out2", out_at(2), 318);
    expect_interleave(512);
    check_block(512, "t1");
    for (int i = 0; i < 512; i++) t1_out[i] = out_at(i);

    // K=6144 interleave, ramp data with random gaps and a stray strobe mid-write.
    for (int i = 0; i < 6144; i++) data[i] = i;
    outq.delete();
    start_block(6144, 1'b0);
    send_block(6144, 1'b1, 1'b1);
    wait_done(6144, "t2");
    check("t2 out0", out_at(0), 0);
    check("t2 out1", out_at(1), 743);
    check("t2 out2", out_at(2), 2446);
    expect_interleave(6144);
    check_block(6144, "t2");

    // K=512 de-interleave of the first block's output: round trip is identity.
    for (int i = 0; i < 512; i++) data[i] = t1_out[i];
    outq.delete();
    start_block(512, 1'b1);
    send_block(512, 1'b0, 1'b0);
    wait_done(512, "t3");
    expect_deinterleave(512);
    check_block(512, "t3");
    check("t3 identity k=511", out_at(511), 511);

    // Unsupported block length, then a normal block.
    err_pulses = 0;
    @(negedge clk);
    blklen       = 16'd1000;
    valid_blklen = 1'b1;
    @(negedge clk);
    valid_blklen = 1'b0;
    check("t4 err pulse", int'(err), 1);
    check("t4 busy stays low", int'(busy), 0);
    @(negedge clk);
    check("t4 err single cycle", int'(err), 0);
    check("t4 busy still low", int'(busy), 0);
    check("t4 err pulse count", err_pulses, 1);
    random_data(512);
    outq.delete();
    start_block(512, 1'b0);
    send_block(512, 1'b1, 1'b0);
    wait_done(512, "t4");
    expect_interleave(512);
    check_block(512, "t4");

    // Overrun: extrinsic during IDLE is silent, during READ each cycle pulses err.
    err_pulses = 0;
    @(negedge clk);
    valid_extrinsic = 1'b1;
    extrinsic       = 16'hdead;
    @(negedge clk);
    valid_extrinsic = 1'b0;
    repeat (2) @(negedge clk);
    check("t5 idle drop no err", err_pulses, 0);
    random_data(512);
    outq.delete();
    start_block(512, 1'b1);
    send_block(512, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      valid_extrinsic = 1'b1;
      extrinsic       = DATA_W'($urandom_range(0, 65535));
      @(negedge clk);
      valid_extrinsic = 1'b0;
      repeat (3) @(negedge clk);
    end
    wait_done(512, "t5");
    check("t5 overrun err pulses", err_pulses, 4);
    expect_deinterleave(512);
    check_block(512, "t5");

    // Asynchronous reset in the middle of a K=6144 read, then a fresh block.
    random_data(6144);
    outq.delete();
    start_block(6144, 1'b0);
    send_block(6144, 1'b0, 1'b0);
    begin
      int t = 0;
      while (outq.size() < 100 && t < 20000) begin
        @(negedge clk);
        t++;
      end
      check("t6 reached output 100", int'(outq.size() >= 100), 1);
    end
    check("t6 busy before reset", int'(busy), 1);
    #1 rst = 1'b0;
    #1;
    check("t6 async apriori", int'(apriori), 0);
    check("t6 async valid_apriori", int'(valid_apriori), 0);
    check("t6 async busy", int'(busy), 0);
    check("t6 async err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    random_data(512);
    outq.delete();
    start_block(512, 1'b0);
    send_block(512, 1'b0, 1'b0);
    wait_done(512, "t6");
    expect_interleave(512);
    check_block(512, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
